arb_request_agent: RTL

Requester-side agent for the team's combinational one-hot request/grant arbiters. It queues jobs per channel and drives the `req` vector into the arbiter. It consumes the returned `grant`, holds the winning channel's ownership for a programmable number of beats, and reports completion. It also checks the grant for protocol violations.

---
 rtl/arb_request_agent_if.sv | 19 +
 rtl/arb_request_agent.sv | 67 ++++++
 2 files changed

// File: rtl/arb_request_agent_if.sv
// arb_request_agent_if: job/request/grant bundle between the agent and its environment
// master: agent view (drives job_ready, req, active, done, busy, err)
// slave: environment view (drives job_valid, beats, grant)
interface arb_request_agent_if #(
  parameter int N = 8,
  parameter int BEAT_W = 4
);
  logic [N-1:0] job_valid;
  logic [N-1:0] job_ready;
  logic [BEAT_W-1:0] beats;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] active;
  logic [N-1:0] done;
  logic busy;
  logic err;
  modport master (input job_valid, beats, grant, output job_ready, req, active, done, busy, err);
  modport slave (output job_valid, beats, grant, input job_ready, req, active, done, busy, err);
endinterface

// File: rtl/arb_request_agent.sv
// arb_request_agent: per-channel job queue driving a one-hot arbiter, tenure tracking and grant checking
// clk, rst_n (async active-low); bus: job_valid/job_ready/beats in, req/grant to arbiter,
// active/done/busy tenure status, err sticky protocol flag
module arb_request_agent #(
  parameter int N = 8,
  parameter int CNT_W = 4,
  parameter int BEAT_W = 4
) (
  input logic clk,
  input logic rst_n,
  arb_request_agent_if.master bus
);
  typedef enum logic {IDLE, OWN} state_t;
  localparam logic [CNT_W-1:0] PMAX = '1;
  state_t state, state_nx;
  logic [CNT_W-1:0] pend [N];
  logic [N-1:0] owner, pend_nz, ready, req, done;
  logic [BEAT_W-1:0] bcnt;
  logic grant_ok, last, err;
  always_comb begin
    for (int k = 0; k < N; k++) begin
      pend_nz[k] = pend[k] != '0;
      ready[k] = pend[k] != PMAX;
    end
    last = state == OWN && bcnt == BEAT_W'(1);
    // owner-only request in OWN keeps a fixed-priority arbiter locked on us
    req = state == OWN ? owner : pend_nz;
    grant_ok = $onehot(bus.grant) && (bus.grant & ~req) == '0;
    done = last ? owner : '0;
    state_nx = state == IDLE ? (grant_ok ? OWN : IDLE) : (last ? IDLE : OWN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      bcnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant_ok) begin
        owner <= bus.grant;
        bcnt <= bus.beats == '0 ? BEAT_W'(1) : bus.beats;
      end else if (state == OWN) begin
        bcnt <= bcnt - 1'b1;
      end
      if ((state == IDLE && bus.grant != '0 && !grant_ok) || (state == OWN && bus.grant != owner))
        err <= 1'b1;
    end
  end
  // a job arriving on the same edge as that channel's done cancels out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) pend[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (bus.job_valid[k] && ready[k] && !done[k]) pend[k] <= pend[k] + 1'b1;
        else if (done[k] && !(bus.job_valid[k] && ready[k])) pend[k] <= pend[k] - 1'b1;
      end
    end
  end
  assign bus.req = req;
  assign bus.done = done;
  assign bus.job_ready = ready;
  assign bus.active = state == OWN ? owner : '0;
  assign bus.busy = state == OWN;
  assign bus.err = err;
endmodule
